knap_search_ctrl: RTL and testbench

- Exhaustive-search controller that sits directly upstream of the 16-variable knapsack validity checker.
- Walks a programmable inclusive range of 16-bit candidate assignments, one per cycle, and drives each candidate onto the checker's item inputs.
- Samples the checker's combinational `valid` result and pushes every valid candidate into an internal solution FIFO. A downstream consumer drains the FIFO over a valid/ready handshake.
- Keeps a running count of valid solutions.

---
 rtl/knap_search_ctrl.sv | 129 ++++++++++++
 tb/tb_knap_search_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/knap_search_ctrl.sv
// Exhaustive search over a candidate range, feeding the knapsack checker.
// Valid candidates are collected in a first-word fall-through solution FIFO.
module knap_search_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CAND_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CAND_W-1:0] range_lo,
   input  logic [CAND_W-1:0] range_hi,
   output logic [CAND_W-1:0] cand,
   input  logic              cand_ok,
   output logic              sol_valid,
   input  logic              sol_ready,
   output logic [CAND_W-1:0] sol_data,
   output logic [CAND_W:0]   sol_count,
   output logic              busy,
   output logic              done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

   state_t            state_q, state_d;
   logic [CAND_W-1:0] cand_q, cand_d;
   logic [CAND_W-1:0] hi_q, hi_d;
   logic [CAND_W:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [CAND_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wp_q, wp_d;
   logic [AW-1:0]     rp_q, rp_d;
   logic [AW:0]       fc_q, fc_d;

   logic full, pop, push, stall, wr;

   assign full  = (fc_q == DEPTH_C);
   assign pop   = sol_valid && sol_ready;
   assign push  = (state_q == SCAN) && cand_ok;
   // A pop in the same cycle frees the slot, so a full FIFO need not stall.
   assign stall = push && full && !pop;
   assign wr    = push && !stall;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               hi_d   = range_hi;
               cand_d = range_lo;
               cnt_d  = '0;
               done_d = 1'b0;
               if (range_lo <= range_hi) begin
                  state_d = SCAN;
                  busy_d  = 1'b1;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         SCAN: begin
            if (!stall) begin
               if (wr) cnt_d = cnt_q + (CAND_W+1)'(1);
               if (cand_q == hi_q) state_d = FINISH;
               else cand_d = cand_q + CAND_W'(1);
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wp_d = wr  ? wp_q + AW'(1) : wp_q;
      rp_d = pop ? rp_q + AW'(1) : rp_q;
      fc_d = fc_q;
      if (wr && !pop) fc_d = fc_q + (AW+1)'(1);
      if (pop && !wr) fc_d = fc_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         fc_q    <= fc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wp_q] <= cand_q;
   end

   assign cand      = cand_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sol_count = cnt_q;
   assign sol_valid = (fc_q != '0);
   assign sol_data  = mem_q[rp_q];

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Randomised bench for knap_search_ctrl with a stub checker and a
// queue-based scoreboard of expected solutions.
module tb_knap_search_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] range_lo = '0;
   logic [15:0] range_hi = '0;
   logic [15:0] cand;
   logic        cand_ok;
   logic        sol_valid;
   logic        sol_ready;
   logic [15:0] sol_data;
   logic [16:0] sol_count;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int mode = 0;
   int ready_mode = 1;
   logic [15:0] exp_q [$];

   knap_search_ctrl #(.FIFO_DEPTH(8), .CAND_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .range_lo(range_lo), .range_hi(range_hi),
      .cand(cand), .cand_ok(cand_ok),
      .sol_valid(sol_valid), .sol_ready(sol_ready),
      .sol_data(sol_data), .sol_count(sol_count),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Stub checker predicates selected by mode.
   function automatic bit pred(input int m, input int v);
      case (m)
         1: return (v % 4) == 3;
         2: return 1'b1;
         3: return ((v * 7 + 3) % 5) == 0;
         default: return 1'b0;
      endcase
   endfunction

   assign cand_ok = pred(mode, int'(cand));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   initial begin
      sol_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 2) sol_ready = 1'($urandom_range(0, 1));
         else sol_ready = (ready_mode == 1);
      end
   end

   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && sol_valid && sol_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sol_extra: got 0x%0h expected none", sol_data);
            end else begin
               e = exp_q.pop_front();
               chk("sol_data", int'(sol_data), int'(e));
            end
         end
      end
   end

   function automatic int n_sol(input int lo, input int hi);
      int n = 0;
      for (int v = lo; v <= hi; v++) if (pred(mode, v)) n++;
      return n;
   endfunction

   task automatic launch(input int lo, input int hi);
      @(posedge clk); #1;
      range_lo = 16'(lo);
      range_hi = 16'(hi);
      start = 1'b1;
      for (int v = lo; v <= hi; v++)
         if (pred(mode, v)) exp_q.push_back(16'(v));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic run(input int lo, input int hi,
                      input string tag, input bit lat_chk);
      int c;
      int n;
      n = n_sol(lo, hi);
      launch(lo, hi);
      wait_done(c);
      if (lat_chk)
         chk({tag, "_latency"}, c, (lo <= hi) ? hi - lo + 2 : 1);
      chk({tag, "_count"}, int'(sol_count), n);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cand"}, int'(cand), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_count"}, int'(sol_count), 0);
      chk({tag, "_valid"}, int'(sol_valid), 0);
   endtask

   initial begin
      int c;
      int lo;
      int hi;
      #12;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      mode = 0;
      run(0, 0, "t1", 1'b1);
      chk("t1_cand", int'(cand), 0);
      chk("t1_valid", int'(sol_valid), 0);

      mode = 1;
      run(0, 15, "t2", 1'b1);

      ready_mode = 0;
      launch(0, 63);
      repeat (100) begin @(posedge clk); #1; end
      chk("t3_stall_cand", int'(cand), 'h23);
      chk("t3_busy", int'(busy), 1);
      chk("t3_done", int'(done), 0);
      chk("t3_count_full", int'(sol_count), 8);
      chk("t3_valid", int'(sol_valid), 1);
      ready_mode = 1;
      wait_done(c);
      chk("t3_count", int'(sol_count), 16);

      mode = 2;
      run('hFFF0, 'hFFFF, "t4", 1'b1);
      repeat (4) begin @(posedge clk); #1; end
      chk("t4_no_wrap", int'(cand), 'hFFFF);
      chk("t4_busy", int'(busy), 0);

      mode = 1;
      run(5, 3, "t5", 1'b1);
      chk("t5_busy", int'(busy), 0);

      launch('h10, 'h40);
      repeat (5) begin @(posedge clk); #1; end
      range_lo = '0;
      range_hi = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(c);
      chk("ign_latency", c + 6, 'h31 + 1);
      chk("ign_count", int'(sol_count), 12);

      ready_mode = 2;
      for (int i = 0; i < 8; i++) begin
         mode = int'($urandom_range(1, 3));
         lo = int'($urandom_range(0, 65535));
         hi = lo + int'($urandom_range(0, 200));
         if (hi > 65535) hi = 65535;
         if (i == 3 && lo > 0) hi = lo - 1;
         run(lo, hi, "rnd", 1'b0);
      end

      ready_mode = 1;
      mode = 2;
      launch('hF0, 'h200);
      c = 0;
      while (cand != 16'h0100 && c < 1000) begin
         @(posedge clk); #1;
         c++;
      end
      chk("t6_reach", int'(cand), 'h100);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("t6");
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 1;
      run('h20, 'h2F, "t6_rerun", 1'b1);

      repeat (20) @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
      chk("drain_valid", int'(sol_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
